freelist_recovery_ctrl: RTL and testbench
=========================================

# freelist_recovery_ctrl

Physical-register free-list controller for the rename stage. It holds a 64-entry free bitmap and hands the rename stage one free physical register per cycle. It reclaims registers released by the RRAT at commit. After a pipeline FLUSH it runs a multi-cycle sequencer that rebuilds the free set by walking the RRAT architectural map, holding rename off until the free set is consistent again.

## Interface
Parameters:
- PREGS, 64, number of physical registers (the tag is 6 bits wide).
- AREGS, 32, number of architectural registers walked during rebuild.

Ports:
- CLK  in  1  clock; all state updates on negedge CLK, the same edge as rename.
- RESET  in  1  asynchronous, active-low reset.
- STALL  in  1  global stall; blocks allocation only.
- FLUSH  in  1  pipeline flush; starts a rebuild.
- alloc_req  in  1  rename consumes a register this edge (register write or load).
- alloc_valid  out  1  alloc_reg is usable.
- alloc_reg  out  6  lowest-index free physical register (combinational from the bitmap).
- release_valid  in  1  RRAT frees a register at commit.
- release_reg  in  6  register being freed.
- rrat_map  in  6 x AREGS  committed arch-to-physical map.
- free_count  out  7  number of free registers, 0..64.
- free_halt  out  1  rename must halt.
- rebuilding  out  1  rebuild sequencer is active.

## Operation
States:
- IDLE
- REBUILD, with a 5-bit walk index idx.

Reset:
- Bitmap bits 0..31 = used (identity map of the architectural registers); bits 32..63 = free.
- free_count = 32, state = IDLE, idx = 0.

Combinational outputs:
- alloc_valid = (state == IDLE) & (free_count != 0) & !FLUSH.
- alloc_reg = priority encode, lowest set bit of the bitmap; 0 when the bitmap is empty.
- free_halt = (state != IDLE) | (free_count == 0).
- rebuilding = (state == REBUILD).

IDLE, at each edge:
- Allocation fires when alloc_req & alloc_valid & !STALL: clear bit[alloc_reg].
- Release fires when release_valid and bit[release_reg] is currently clear: set bit[release_reg]. Releases are honoured during STALL.
- Releasing an already-free register is ignored; the count is unchanged.
- alloc_reg comes from the pre-edge bitmap, so a same-edge release is never handed out that edge.
- free_count += release_fired - alloc_fired (net 0 when both fire). Width is 7 bits; it never exceeds 64 and never goes below 0.

FLUSH (highest priority, in any state):
- Bitmap becomes all ones, free_count = 64, idx = 0, state = REBUILD.
- No allocation or release takes effect on the flush edge.

REBUILD, at each edge:
- If bit[rrat_map[idx]] is set, clear it and decrement free_count. A duplicate map entry is not double-counted.
- idx increments. When idx == AREGS-1 the clear is applied and state returns to IDLE.
- alloc_req and release_valid are ignored; the ROB is empty after a flush, so no commits occur.
- rrat_map must hold stable for the whole rebuild.

Invariant: free_count equals the population count of the bitmap after every edge.

## Timing
- alloc_reg and alloc_valid are valid before the negedge on which rename samples them. Allocation takes effect on that edge, and the next alloc_reg is visible after it.
- Release is visible in the bitmap and in free_count after the edge. The register can be allocated one cycle later at the earliest.
- Rebuild latency is exactly AREGS (32) edges after the flush edge. alloc_valid rises in the cycle after the 32nd walk edge.
- free_halt is high from the flush edge through the last REBUILD edge. It is also high whenever free_count == 0.
- FLUSH during REBUILD restarts the walk at idx 0 with all bits free.
- RESET low mid-rebuild immediately forces the reset state, asynchronously, regardless of CLK.

## Test plan
- Reset: deassert RESET.
  -> free_count = 32, alloc_reg = 32, alloc_valid = 1, free_halt = 0, rebuilding = 0.
- Sequential allocation: alloc_req high for 32 edges.
  -> alloc_reg steps 32, 33, ..., 63; then free_count = 0, alloc_valid = 0, free_halt = 1.
  -> One further alloc_req leaves free_count at 0.
- Simultaneous events: after allocating 32, assert alloc_req with release_valid/release_reg = 5 on the same edge.
  -> Allocates 33 (not 5); free_count is unchanged; next alloc_reg = 5.
  -> Then release_reg = 5 again: ignored, count unchanged.
- Flush rebuild: rrat_map[i] = i + 10 for all i; pulse FLUSH.
  -> rebuilding = 1 for 32 edges, then IDLE.
  -> free_count = 32, alloc_reg = 0, and regs 10..41 are never allocated.
  -> With rrat_map[1] = rrat_map[0] = 7, free_count = 33 after the rebuild.
- Flush mid-rebuild, and STALL: FLUSH again at idx 17.
  -> The walk restarts and completes 32 edges after the second flush.
  -> STALL with alloc_req high allocates nothing while a release still succeeds.
- Reset mid-rebuild: drop RESET at idx 9, asynchronously between clock edges.
  -> Outputs return to reset values immediately; rebuilding = 0, free_count = 32.

Source files
------------

// File: rtl/freelist_recovery_ctrl.sv
// Physical-register free list for rename: hands out the lowest free register, reclaims
// commit releases, and rebuilds the free set from the RRAT map after a flush.
//
// state     | meaning
// S_IDLE    | normal allocate/release, rename may proceed when a register is free
// S_REBUILD | walking rrat_map[idx], clearing committed registers from an all-free bitmap
module freelist_recovery_ctrl #(
  parameter int PREGS = 64,
  parameter int AREGS = 32
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              STALL,
  input  logic                              FLUSH,
  input  logic                              alloc_req,
  output logic                              alloc_valid,
  output logic [$clog2(PREGS)-1:0]          alloc_reg,
  input  logic                              release_valid,
  input  logic [$clog2(PREGS)-1:0]          release_reg,
  input  logic [AREGS-1:0][$clog2(PREGS)-1:0] rrat_map,
  output logic [$clog2(PREGS):0]            free_count,
  output logic                              free_halt,
  output logic                              rebuilding
);

  localparam int TW = $clog2(PREGS);
  localparam int CW = $clog2(PREGS) + 1;
  localparam int IW = $clog2(AREGS);
  localparam logic [PREGS-1:0] RST_MAP = {{(PREGS-AREGS){1'b1}}, {AREGS{1'b0}}};
  localparam logic [IW-1:0] LAST_IDX = IW'(AREGS - 1);

  typedef enum logic {S_IDLE, S_REBUILD} state_t;

  state_t          r_state;
  logic [PREGS-1:0] r_bitmap;
  logic [CW-1:0]   r_count;
  logic [IW-1:0]   r_idx;

  logic [TW-1:0]   w_alloc_reg;
  logic            w_alloc_valid;
  logic            w_alloc_fire;
  logic            w_rel_fire;
  logic [TW-1:0]   w_walk_reg;

  // Scan high to low so the last hit is the lowest set bit.
  always_comb begin
    w_alloc_reg = '0;
    for (int i = PREGS - 1; i >= 0; i--) begin
      if (r_bitmap[i]) w_alloc_reg = TW'(i);
    end
  end

  assign w_alloc_valid = (r_state == S_IDLE) && (r_count != '0) && !FLUSH;
  assign w_alloc_fire  = alloc_req && w_alloc_valid && !STALL;
  // A register already free is never re-counted; it also can never equal w_alloc_reg.
  assign w_rel_fire    = release_valid && !r_bitmap[release_reg];
  assign w_walk_reg    = rrat_map[r_idx];

  always_ff @(negedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= S_IDLE;
      r_bitmap <= RST_MAP;
      r_count  <= CW'(PREGS - AREGS);
      r_idx    <= '0;
    end else if (FLUSH) begin
      r_state  <= S_REBUILD;
      r_bitmap <= '1;
      r_count  <= CW'(PREGS);
      r_idx    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_alloc_fire) r_bitmap[w_alloc_reg] <= 1'b0;
          if (w_rel_fire)   r_bitmap[release_reg] <= 1'b1;
          r_count <= r_count + CW'(w_rel_fire) - CW'(w_alloc_fire);
        end
        S_REBUILD: begin
          // Duplicate map entries find the bit already clear and are not double-counted.
          if (r_bitmap[w_walk_reg]) begin
            r_bitmap[w_walk_reg] <= 1'b0;
            r_count              <= r_count - CW'(1);
          end
          if (r_idx == LAST_IDX) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alloc_valid = w_alloc_valid;
  assign alloc_reg   = w_alloc_reg;
  assign free_count  = r_count;
  assign free_halt   = (r_state != S_IDLE) || (r_count == '0);
  assign rebuilding  = (r_state == S_REBUILD);

endmodule

// File: tb/tb_freelist_recovery_ctrl.sv
// Directed bench for freelist_recovery_ctrl: allocation order, release rules,
// flush rebuild (incl. restart and duplicates), stall, and async reset mid-rebuild.
module tb_freelist_recovery_ctrl;

  logic             CLK;
  logic             RESET;
  logic             STALL;
  logic             FLUSH;
  logic             alloc_req;
  logic             alloc_valid;
  logic [5:0]       alloc_reg;
  logic             release_valid;
  logic [5:0]       release_reg;
  logic [31:0][5:0] rrat_map;
  logic [6:0]       free_count;
  logic             free_halt;
  logic             rebuilding;

  int errors = 0;
  int checks = 0;

  freelist_recovery_ctrl #(.PREGS(64), .AREGS(32)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
    .alloc_req(alloc_req), .alloc_valid(alloc_valid), .alloc_reg(alloc_reg),
    .release_valid(release_valid), .release_reg(release_reg), .rrat_map(rrat_map),
    .free_count(free_count), .free_halt(free_halt), .rebuilding(rebuilding)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One active (falling) edge, then settle before sampling.
  task automatic step();
    @(negedge CLK);
    #2;
  endtask

  task automatic map_offset();
    for (int i = 0; i < 32; i++) rrat_map[i] = 6'(i + 10);
  endtask

  initial begin
    RESET = 1'b0; STALL = 1'b0; FLUSH = 1'b0; alloc_req = 1'b0;
    release_valid = 1'b0; release_reg = '0;
    map_offset();
    #12 RESET = 1'b1;
    #1;
    chk("rst_count", 32'(free_count), 32);
    chk("rst_alloc_reg", 32'(alloc_reg), 32);
    chk("rst_alloc_valid", 32'(alloc_valid), 1);
    chk("rst_halt", 32'(free_halt), 0);
    chk("rst_rebuilding", 32'(rebuilding), 0);

    // Sequential allocation of 32..63
    alloc_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk("seq_alloc_reg", 32'(alloc_reg), 32'(32 + i));
      step();
    end
    chk("empty_count", 32'(free_count), 0);
    chk("empty_valid", 32'(alloc_valid), 0);
    chk("empty_halt", 32'(free_halt), 1);
    chk("empty_alloc_reg", 32'(alloc_reg), 0);
    step();
    chk("empty_extra_alloc", 32'(free_count), 0);

    // Refill 32,33, allocate 32, then alloc + release(5) on one edge
    alloc_req = 1'b0; release_valid = 1'b1; release_reg = 6'd32;
    step();
    release_reg = 6'd33;
    step();
    chk("refill_count", 32'(free_count), 2);
    release_valid = 1'b0; alloc_req = 1'b1;
    step();
    chk("after_alloc32_reg", 32'(alloc_reg), 33);
    release_valid = 1'b1; release_reg = 6'd5;
    #1;
    chk("simul_pre_reg", 32'(alloc_reg), 33);
    step();
    chk("simul_count", 32'(free_count), 1);
    chk("simul_next_reg", 32'(alloc_reg), 5);
    alloc_req = 1'b0;
    step();
    chk("dup_release_count", 32'(free_count), 1);
    release_valid = 1'b0;

    // Flush rebuild with rrat_map[i] = i + 10
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    chk("flush_rebuilding", 32'(rebuilding), 1);
    chk("flush_count", 32'(free_count), 64);
    chk("flush_halt", 32'(free_halt), 1);
    chk("flush_valid", 32'(alloc_valid), 0);
    for (int i = 0; i < 31; i++) step();
    chk("walk31_rebuilding", 32'(rebuilding), 1);
    step();
    chk("walk32_rebuilding", 32'(rebuilding), 0);
    chk("rebuild_count", 32'(free_count), 32);
    chk("rebuild_alloc_reg", 32'(alloc_reg), 0);
    chk("rebuild_valid", 32'(alloc_valid), 1);
    chk("rebuild_halt", 32'(free_halt), 0);
    alloc_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk("post_rebuild_alloc", 32'(alloc_reg), (i < 10) ? 32'(i) : 32'(i + 32));
      step();
    end
    alloc_req = 1'b0;
    chk("post_rebuild_drain", 32'(free_count), 0);

    // Duplicate map entries: map[0] = map[1] = 7
    rrat_map[0] = 6'd7; rrat_map[1] = 6'd7;
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    for (int i = 0; i < 32; i++) step();
    chk("dup_map_count", 32'(free_count), 33);
    chk("dup_map_rebuilding", 32'(rebuilding), 0);

    // Flush again at idx 17
    map_offset();
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    for (int i = 0; i < 17; i++) step();
    chk("idx17_count", 32'(free_count), 47);
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    chk("reflush_count", 32'(free_count), 64);
    for (int i = 0; i < 31; i++) step();
    chk("reflush_walk31", 32'(rebuilding), 1);
    step();
    chk("reflush_walk32", 32'(rebuilding), 0);
    chk("reflush_final_count", 32'(free_count), 32);

    // STALL blocks allocation but not release
    STALL = 1'b1; alloc_req = 1'b1; release_valid = 1'b1; release_reg = 6'd20;
    step();
    chk("stall_count", 32'(free_count), 33);
    chk("stall_alloc_reg", 32'(alloc_reg), 0);
    STALL = 1'b0; alloc_req = 1'b0; release_valid = 1'b0;

    // Async reset at idx 9, between edges
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("pre_reset_rebuilding", 32'(rebuilding), 1);
    #1 RESET = 1'b0;
    #1;
    chk("async_rst_rebuilding", 32'(rebuilding), 0);
    chk("async_rst_count", 32'(free_count), 32);
    chk("async_rst_alloc_reg", 32'(alloc_reg), 32);
    chk("async_rst_halt", 32'(free_halt), 0);
    chk("async_rst_valid", 32'(alloc_valid), 1);
    RESET = 1'b1;
    step();
    chk("post_reset_count", 32'(free_count), 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
